// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-channel registered arbiter/mux.
package mux_pkg;

    // Arbitration policy selector values for the MODE parameter.
    localparam int MODE_FIXED = 0;   // lowest channel index wins
    localparam int MODE_RR    = 1;   // round-robin starting at rr_ptr

    // Width needed to encode n distinct indices, never less than one bit,
    // so a single-channel build still has a legal index port.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/arb_rr_nch.sv
// Combinational N-way arbiter: picks one requester by fixed priority or by
// round-robin search starting at rr_ptr, producing a one-hot grant and its
// encoded index.
module arb_rr_nch
    import mux_pkg::*;
#(
    parameter  int NCH  = 4,
    parameter  int MODE = MODE_RR,
    localparam int SELW = clog2_min1(NCH)
) (
    input  logic [NCH-1:0]  in_valid,
    input  logic [SELW-1:0] rr_ptr,
    output logic [NCH-1:0]  grant,
    output logic [SELW-1:0] grant_idx,
    output logic            grant_vld
);

    // Search channels in order base, base+1, ... (mod NCH); first requester wins.
    always_comb begin
        int base;
        int idx;
        // NOTE: every combinational output gets a default before any branch,
        // otherwise paths that skip an assignment infer a latch.
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        base      = (MODE == MODE_RR) ? int'(rr_ptr) : 0;
        idx       = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = base + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            for (int i = 0; i < NCH; i++) begin
                if (!grant_vld && (i == idx) && in_valid[i]) begin
                    grant[i]  = 1'b1;
                    grant_idx = SELW'(i);
                    grant_vld = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mux_arb_nch.sv
// N-channel registered multiplexer with valid/ready handshake. One channel
// is granted per cycle and its data captured in a one-entry output stage
// that can drain and reload on the same edge for full throughput.
module mux_arb_nch
    import mux_pkg::*;
#(
    parameter  int NBITS = 32,
    parameter  int NCH   = 4,
    parameter  int MODE  = MODE_RR,
    localparam int SELW  = clog2_min1(NCH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NCH*NBITS-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [NBITS-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [NCH-1:0]   grant;
    logic [SELW-1:0]  grant_idx;
    logic             grant_vld;
    logic             load_en;
    logic             xfer;
    logic [NBITS-1:0] sel_data;

    logic [NBITS-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_ch_q,    out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

    arb_rr_nch #(
        .NCH  (NCH),
        .MODE (MODE)
    ) u_arb (
        .in_valid  (in_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // The stage can accept a new beat when empty or when being drained now.
    // A beat moves only on the granted channel; reset blocks all acceptance.
    assign load_en  = ~out_valid_q | out_ready;
    assign in_ready = grant & {NCH{load_en & reset_n}};
    assign xfer     = grant_vld & load_en & reset_n;

    // One-hot AND-OR select of the granted channel's data.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NCH; i++) begin
            sel_data = sel_data | (in_data[i*NBITS +: NBITS] & {NBITS{grant[i]}});
        end
    end

    // Output stage next state: load on transfer, empty on an idle load slot,
    // otherwise hold (covers the stalled case).
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        if (load_en) begin
            if (grant_vld) begin
                out_data_d  = sel_data;
                out_ch_d    = grant_idx;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Round-robin pointer moves to the channel after the one just served;
    // it stays at zero in fixed-priority mode.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if ((MODE == MODE_RR) && xfer) begin
            rr_ptr_d = (grant_idx == SELW'(NCH - 1)) ? '0 : grant_idx + SELW'(1);
        end
    end

    // State registers with synchronous active-low reset; reset discards any held beat.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (!reset_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule
